// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types for the two-master memory port arbiter: FSM state, owner
// encoding and default bus geometry.
package bus_pkg;

  localparam int ADDR_W_DEF      = 64;
  localparam int DATA_W_DEF      = 64;
  localparam int TIMEOUT_CYC_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RSP  = 2'd2
  } state_e;

  // m0 is instruction fetch, m1 is the load/store unit
  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_e;

  function automatic owner_e owner_from_grant(input logic [1:0] grant);
    return grant[1] ? OWN_LS : OWN_IF;
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Request/response bus between a requester and a memory slave. The arbiter
// takes the slave modport toward each core master and the master modport
// toward the memory.
interface mem_bus_if #(
  parameter int ADDR_W = bus_pkg::ADDR_W_DEF,
  parameter int DATA_W = bus_pkg::DATA_W_DEF
);
  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_W-1:0]     addr;
  logic                  we;
  logic [DATA_W-1:0]     wdata;
  logic [DATA_W/8-1:0]   wstrb;
  logic                  rsp_valid;
  logic [DATA_W-1:0]     rdata;
  logic                  rsp_err;

  modport master (
    output req_valid, addr, we, wdata, wstrb,
    input  req_ready, rsp_valid, rdata, rsp_err
  );

  modport slave (
    input  req_valid, addr, we, wdata, wstrb,
    output req_ready, rsp_valid, rdata, rsp_err
  );
endinterface

// File: rtl/mem_bus_arbiter_arb_pick.sv
// Combinational winner select between the two requesters.
// ARB_ROUND_ROBIN_EN defined: simultaneous requests go to the master that did
// not win last; otherwise the load/store unit (m1) always wins.
module arb_pick
  import bus_pkg::*;
(
  input  logic [1:0] req_valid_i,
  input  owner_e     last_owner_i,
  output logic [1:0] grant_o
);

`ifdef ARB_ROUND_ROBIN_EN
  // Alternate on contention, a lone request always wins
  always_comb begin
    // NOTE: every combinational output gets a default before the case so no path can infer a latch.
    grant_o = 2'b00;
    case (req_valid_i)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      2'b11:   grant_o = (last_owner_i == OWN_LS) ? 2'b01 : 2'b10;
      default: grant_o = 2'b00;
    endcase
  end
`else
  // Fixed priority ignores history
  logic unused_last_owner;
  assign unused_last_owner = last_owner_i;

  // m1 beats m0 whenever it requests
  always_comb begin
    grant_o = 2'b00;
    if (req_valid_i[1])      grant_o = 2'b10;
    else if (req_valid_i[0]) grant_o = 2'b01;
  end
`endif

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares the single memory port between instruction fetch (m0) and the
// load/store unit (m1). One transaction outstanding at a time; a watchdog
// turns a hung slave into an error response after TIMEOUT_CYC cycles.
// Optional feature: ARB_ROUND_ROBIN_EN selects round-robin arbitration.
module mem_bus_arbiter
  import bus_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic      clk,
  input  logic      rst,
  mem_bus_if.slave  m0_bus,
  mem_bus_if.slave  m1_bus,
  mem_bus_if.master s_bus
);

  localparam int WDOG_W = $clog2(TIMEOUT_CYC);
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT_CYC - 1);

  state_e                state_q, state_d;
  owner_e                owner_q, owner_d;
  owner_e                last_owner_q, last_owner_d;
  logic [WDOG_W-1:0]     wdog_q, wdog_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic                  we_q, we_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic [DATA_W/8-1:0]   wstrb_q, wstrb_d;

  logic [1:0]            req_valid;
  logic [1:0]            grant;
  logic                  rsp_ok;
  logic                  rsp_timeout;
  logic                  rsp_fire;
  logic [DATA_W-1:0]     rsp_data;

  // The memory has no error signalling of its own
  logic unused_s_rsp_err;
  assign unused_s_rsp_err = s_bus.rsp_err;

  assign req_valid = {m1_bus.req_valid, m0_bus.req_valid};

  arb_pick u_arb_pick (
    .req_valid_i  (req_valid),
    .last_owner_i (last_owner_q),
    .grant_o      (grant)
  );

  // A real response always beats a timeout landing on the same cycle
  assign rsp_ok      = (state_q == RSP) && s_bus.rsp_valid;
  assign rsp_timeout = (state_q == RSP) && !s_bus.rsp_valid && (wdog_q == WDOG_LAST);
  assign rsp_fire    = rsp_ok || rsp_timeout;

  // State and captured-request registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= OWN_IF;
      last_owner_q <= OWN_LS;
      wdog_q       <= '0;
      addr_q       <= '0;
      we_q         <= 1'b0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      wdog_q       <= wdog_d;
      addr_q       <= addr_d;
      we_q         <= we_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
    end
  end

  // Next state: grant and capture in IDLE, hand off in REQ, wait or time out in RSP
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    wdog_d       = wdog_q;
    addr_d       = addr_q;
    we_d         = we_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    case (state_q)
      IDLE: begin
        if (|req_valid) begin
          state_d      = REQ;
          owner_d      = owner_from_grant(grant);
          last_owner_d = owner_from_grant(grant);
          addr_d       = grant[1] ? m1_bus.addr  : m0_bus.addr;
          we_d         = grant[1] ? m1_bus.we    : m0_bus.we;
          wdata_d      = grant[1] ? m1_bus.wdata : m0_bus.wdata;
          wstrb_d      = grant[1] ? m1_bus.wstrb : m0_bus.wstrb;
        end
      end
      REQ: begin
        if (s_bus.req_ready) begin
          state_d = RSP;
          wdog_d  = '0;
        end
      end
      RSP: begin
        // The watchdog holds its value on exit, so it never wraps
        if (rsp_fire) state_d = IDLE;
        else          wdog_d  = wdog_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs: slave request from registers, ready to the winner, response to the owner
  always_comb begin
    s_bus.req_valid  = (state_q == REQ);
    s_bus.addr       = addr_q;
    s_bus.we         = we_q;
    s_bus.wdata      = wdata_q;
    s_bus.wstrb      = wstrb_q;

    // Ready is held low while reset is asserted so no request is taken then
    m0_bus.req_ready = !rst && (state_q == IDLE) && grant[0];
    m1_bus.req_ready = !rst && (state_q == IDLE) && grant[1];

    rsp_data         = rsp_ok ? s_bus.rdata : '0;
    m0_bus.rsp_valid = rsp_fire    && (owner_q == OWN_IF);
    m1_bus.rsp_valid = rsp_fire    && (owner_q == OWN_LS);
    m0_bus.rsp_err   = rsp_timeout && (owner_q == OWN_IF);
    m1_bus.rsp_err   = rsp_timeout && (owner_q == OWN_LS);
    m0_bus.rdata     = (owner_q == OWN_IF) ? rsp_data : '0;
    m1_bus.rdata     = (owner_q == OWN_LS) ? rsp_data : '0;
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed scenarios followed by
// randomized transactions, all checked against a transaction-level model of
// the arbitration and response rules.
module tb_mem_bus_arbiter;

  localparam int AW      = 64;
  localparam int DW      = 64;
  localparam int TIMEOUT = 16;

  typedef struct {
    bit          valid;
    logic [63:0] addr;
    logic        we;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
  } req_t;

  logic clk;
  logic rst;

  mem_bus_if #(.ADDR_W(AW), .DATA_W(DW)) m0_bus ();
  mem_bus_if #(.ADDR_W(AW), .DATA_W(DW)) m1_bus ();
  mem_bus_if #(.ADDR_W(AW), .DATA_W(DW)) s_bus ();

  mem_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TIMEOUT)) dut (
    .clk    (clk),
    .rst    (rst),
    .m0_bus (m0_bus),
    .m1_bus (m1_bus),
    .s_bus  (s_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  req_t pend[2];
  req_t cur;
  int   last_owner = 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled 2 units later
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Model: which master the spec's arbitration rule grants
  function automatic int model_pick(input bit v0, input bit v1, input int last);
    if (v0 && v1) begin
`ifdef ARB_ROUND_ROBIN_EN
      return 1 - last;
`else
      return 1;
`endif
    end
    return v1 ? 1 : 0;
  endfunction

  task automatic drive_masters();
    m0_bus.req_valid = pend[0].valid;
    m0_bus.addr      = pend[0].addr;
    m0_bus.we        = pend[0].we;
    m0_bus.wdata     = pend[0].wdata;
    m0_bus.wstrb     = pend[0].wstrb;
    m1_bus.req_valid = pend[1].valid;
    m1_bus.addr      = pend[1].addr;
    m1_bus.we        = pend[1].we;
    m1_bus.wdata     = pend[1].wdata;
    m1_bus.wstrb     = pend[1].wstrb;
  endtask

  task automatic set_req(input int idx, input logic [63:0] addr, input logic we,
                         input logic [63:0] wdata, input logic [7:0] wstrb);
    pend[idx].valid = 1'b1;
    pend[idx].addr  = addr;
    pend[idx].we    = we;
    pend[idx].wdata = wdata;
    pend[idx].wstrb = wstrb;
  endtask

  task automatic gen_req(input int idx);
    set_req(idx, {$urandom(), $urandom()}, 1'($urandom_range(0, 1)),
            {$urandom(), $urandom()}, 8'($urandom()));
  endtask

  task automatic check_rsp(input string tag, input int w, input bit v, input bit err,
                           input logic [63:0] rd);
    check({tag, "_rsp_valid0"}, m0_bus.rsp_valid, v && w == 0);
    check({tag, "_rsp_valid1"}, m1_bus.rsp_valid, v && w == 1);
    check({tag, "_rsp_err0"},   m0_bus.rsp_err,   err && w == 0);
    check({tag, "_rsp_err1"},   m1_bus.rsp_err,   err && w == 1);
    check({tag, "_rdata0"},     m0_bus.rdata,     (w == 0) ? rd : 64'h0);
    check({tag, "_rdata1"},     m1_bus.rdata,     (w == 1) ? rd : 64'h0);
  endtask

  task automatic do_accept(output int w);
    drive_masters();
    #2;
    w = model_pick(pend[0].valid, pend[1].valid, last_owner);
    check("accept_ready0", m0_bus.req_ready, w == 0);
    check("accept_ready1", m1_bus.req_ready, w == 1);
    check("accept_s_req_valid", s_bus.req_valid, 1'b0);
    next_cycle();
    last_owner     = w;
    cur            = pend[w];
    pend[w].valid  = 1'b0;
    drive_masters();
  endtask

  task automatic do_req(input int dly);
    for (int k = 0; k <= dly; k++) begin
      s_bus.req_ready = (k == dly);
      #2;
      check("req_s_req_valid", s_bus.req_valid, 1'b1);
      check("req_s_addr",      s_bus.addr,      cur.addr);
      check("req_s_we",        s_bus.we,        cur.we);
      check("req_s_wdata",     s_bus.wdata,     cur.wdata);
      check("req_s_wstrb",     s_bus.wstrb,     cur.wstrb);
      check("req_ready0_busy", m0_bus.req_ready, 1'b0);
      check("req_ready1_busy", m1_bus.req_ready, 1'b0);
      check_rsp("req", 0, 1'b0, 1'b0, 64'h0);
      next_cycle();
    end
    s_bus.req_ready = 1'b0;
  endtask

  // dly = RSP cycle on which the slave answers; >= TIMEOUT means never
  task automatic do_rsp(input int dly, input logic [63:0] rd, input int w);
    for (int k = 0; k < TIMEOUT; k++) begin
      bit fire;
      bit to;
      fire            = (k == dly);
      to              = (k == TIMEOUT - 1);
      s_bus.rsp_valid = fire;
      s_bus.rdata     = fire ? rd : {$urandom(), $urandom()};
      #2;
      check("rsp_s_req_valid", s_bus.req_valid, 1'b0);
      check_rsp("rsp", w, fire || to, !fire && to, fire ? rd : 64'h0);
      next_cycle();
      if (fire || to) break;
    end
    s_bus.rsp_valid = 1'b0;
  endtask

  task automatic run_txn(input bit new0, input bit new1, input int rdy_dly,
                         input int rsp_dly, input logic [63:0] rd);
    int w;
    if (new0 && !pend[0].valid) gen_req(0);
    if (new1 && !pend[1].valid) gen_req(1);
    if (!pend[0].valid && !pend[1].valid) gen_req(0);
    do_accept(w);
    do_req(rdy_dly);
    do_rsp(rsp_dly, rd, w);
  endtask

  // One IDLE cycle with no requests, optionally with a stray slave response
  task automatic idle_cycle(input bit late);
    drive_masters();
    s_bus.rsp_valid = late;
    s_bus.rdata     = {$urandom(), $urandom()};
    #2;
    check("idle_ready0", m0_bus.req_ready, 1'b0);
    check("idle_ready1", m1_bus.req_ready, 1'b0);
    check("idle_s_req_valid", s_bus.req_valid, 1'b0);
    check_rsp("idle", 0, 1'b0, 1'b0, 64'h0);
    next_cycle();
    s_bus.rsp_valid = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready0"},     m0_bus.req_ready, 1'b0);
    check({tag, "_ready1"},     m1_bus.req_ready, 1'b0);
    check({tag, "_s_req_valid"}, s_bus.req_valid, 1'b0);
    check({tag, "_s_addr"},     s_bus.addr,       64'h0);
    check({tag, "_s_we"},       s_bus.we,         1'b0);
    check({tag, "_s_wdata"},    s_bus.wdata,      64'h0);
    check({tag, "_s_wstrb"},    s_bus.wstrb,      8'h0);
    check_rsp(tag, 0, 1'b0, 1'b0, 64'h0);
  endtask

  initial begin
    int w;
    rst             = 1'b1;
    s_bus.req_ready = 1'b0;
    s_bus.rsp_valid = 1'b0;
    s_bus.rdata     = '0;
    s_bus.rsp_err   = 1'b0;
    for (int i = 0; i < 2; i++) pend[i] = '{1'b0, 64'h0, 1'b0, 64'h0, 8'h0};
    gen_req(0);
    gen_req(1);
    drive_masters();

    // Reset state, with both masters requesting
    #3;
    check_all_zero("reset");
    next_cycle();
    next_cycle();
    pend[0].valid = 1'b0;
    pend[1].valid = 1'b0;
    drive_masters();
    rst        = 1'b0;
    last_owner = 1;

    // 1: m0 read, immediate slave, response two cycles after accept
    set_req(0, 64'h0000_0000_8000_0000, 1'b0, 64'h0, 8'hFF);
    run_txn(1'b0, 1'b0, 0, 0, 64'h0000_0000_DEAD_BEEF);

    // 2: both masters requesting back-to-back, then the remaining one
    for (int i = 0; i < 4; i++) run_txn(1'b1, 1'b1, 0, 0, {$urandom(), $urandom()});
    run_txn(1'b0, 1'b0, 0, 1, {$urandom(), $urandom()});
    if (pend[0].valid || pend[1].valid) run_txn(1'b0, 1'b0, 0, 0, {$urandom(), $urandom()});

    // 3: slave stalls the request five cycles, fields must stay stable
    run_txn(1'b1, 1'b0, 5, 1, {$urandom(), $urandom()});

    // 4: m1 write, slave never answers -> timeout, then a late response is dropped
    set_req(1, 64'h0000_0000_1000_0040, 1'b1, 64'h1122_3344_5566_7788, 8'h0F);
    run_txn(1'b0, 1'b0, 0, 100, 64'h0);
    idle_cycle(1'b1);

    // 6: response arrives on the watchdog's last cycle
    run_txn(1'b0, 1'b1, 0, TIMEOUT - 1, 64'hCAFE_F00D_0123_4567);

    // 5: reset during RSP abandons the transaction
    gen_req(0);
    do_accept(w);
    do_req(0);
    s_bus.rsp_valid = 1'b0;
    #2;
    check_rsp("rst_pre", w, 1'b0, 1'b0, 64'h0);
    next_cycle();
    gen_req(1);
    drive_masters();
    s_bus.rsp_valid = 1'b1;
    s_bus.rdata     = 64'hFFFF_0000_FFFF_0000;
    s_bus.req_ready = 1'b1;
    rst             = 1'b1;
    #2;
    check_all_zero("rst_mid");
    next_cycle();
    #2;
    check_all_zero("rst_hold");
    next_cycle();
    rst             = 1'b0;
    s_bus.rsp_valid = 1'b0;
    s_bus.req_ready = 1'b0;
    pend[0].valid   = 1'b0;
    pend[1].valid   = 1'b0;
    last_owner      = 1;
    set_req(0, 64'h0000_0000_8000_0100, 1'b0, 64'h0, 8'hFF);
    run_txn(1'b0, 1'b0, 0, 0, 64'h0BAD_C0DE_0000_0001);

    // Randomized transactions
    for (int i = 0; i < 40; i++) begin
      int sel;
      int rsp;
      sel = $urandom_range(0, 7);
      rsp = (sel < 5) ? sel : ((sel == 5) ? TIMEOUT - 1 : 100);
      run_txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              $urandom_range(0, 3), rsp, {$urandom(), $urandom()});
      if (!pend[0].valid && !pend[1].valid && $urandom_range(0, 2) == 0)
        idle_cycle(1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
